// File: rtl/sdpram_pkg.sv
// sdpram_pkg: shared defaults and the round-robin pick function for sdpram_arbiter.
package sdpram_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MEM_DEPTH = 1024;
    localparam int MAX_REQ = 8;
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req, input logic [2:0] ptr, input int n);
        logic [MAX_REQ-1:0] g;
        int idx;
        g = '0;
        // Scan from the farthest offset down so the nearest requester after ptr wins.
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && req[idx]) g = {{(MAX_REQ-1){1'b0}}, 1'b1} << idx;
        end
        return g;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant; pointer moves past the winner only when advance is set.
module rr_arbiter import sdpram_pkg::*; #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    logic [PW-1:0] ptr, nxt;
    assign gnt = rst ? NUM_REQ'(rr_pick(MAX_REQ'(req), 3'(ptr), NUM_REQ)) : '0;
    always_comb begin
        nxt = ptr;
        for (int i = 0; i < NUM_REQ; i++)
            if (gnt[i]) nxt = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr <= '0;
        else if (advance && |gnt) ptr <= nxt;
    end
endmodule

// File: rtl/sdpram_arbiter.sv
// sdpram_arbiter: shares the simple dual-port RAM's write and read ports among NUM_REQ clients,
// routing read responses back by id and deferring reads that collide with a same-cycle write.
module sdpram_arbiter import sdpram_pkg::*; #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  wr_req,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  wr_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  wr_data,
    input  logic [NUM_REQ-1:0][STRB_WIDTH-1:0]  wr_strb,
    output logic [NUM_REQ-1:0]                  wr_gnt,
    input  logic [NUM_REQ-1:0]                  rd_req,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  rd_addr,
    output logic [NUM_REQ-1:0]                  rd_gnt,
    output logic [NUM_REQ-1:0]                  rd_valid,
    output logic [DATA_WIDTH-1:0]               rd_data,
    output logic [STRB_WIDTH-1:0]               wena,
    output logic [ADDR_WIDTH-1:0]               addra,
    output logic [DATA_WIDTH-1:0]               dina,
    output logic                                renb,
    output logic [ADDR_WIDTH-1:0]               addrb,
    input  logic [DATA_WIDTH-1:0]               doutb
);
    logic [NUM_REQ-1:0] rd_cand, rd_id;
    logic [ADDR_WIDTH-1:0] sel_wa, sel_ra;
    logic [DATA_WIDTH-1:0] sel_wd;
    logic [STRB_WIDTH-1:0] sel_ws;
    logic coll;
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (.clk(clk), .rst(rst), .req(wr_req), .advance(1'b1), .gnt(wr_gnt));
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (.clk(clk), .rst(rst), .req(rd_req), .advance(!coll), .gnt(rd_cand));
    always_comb begin
        sel_wa = '0;
        sel_wd = '0;
        sel_ws = '0;
        sel_ra = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wr_gnt[i]) begin
                sel_wa = wr_addr[i];
                sel_wd = wr_data[i];
                sel_ws = wr_strb[i];
            end
            if (rd_cand[i]) sel_ra = rd_addr[i];
        end
    end
    // A read issued alongside a real write to its address would fetch stale data; retry it next cycle.
    assign coll = |wr_gnt && |sel_ws && |rd_cand && (sel_ra == sel_wa);
    assign rd_gnt = coll ? '0 : rd_cand;
    // doutb is already the RAM's output register, so it is presented directly in the response cycle.
    assign rd_data = |rd_valid ? doutb : '0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wena <= '0;
            addra <= '0;
            dina <= '0;
            renb <= 1'b0;
            addrb <= '0;
            rd_id <= '0;
            rd_valid <= '0;
        end else begin
            wena <= |wr_gnt ? sel_ws : '0;
            if (|wr_gnt) begin
                addra <= sel_wa;
                dina <= sel_wd;
            end
            renb <= |rd_gnt;
            if (|rd_gnt) addrb <= sel_ra;
            rd_id <= rd_gnt;
            rd_valid <= rd_id;
        end
    end
endmodule
